// File: rtl/fsm_stim_pkg.sv
// Shared definitions for the serial stimulus transmitter: state codes and
// the word-length normalisation used when a word is accepted.
package fsm_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // A length of zero means a full word; anything longer than the word is clamped.
  function automatic int eff_len(input int len, input int data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register. out_bit is the bit to present on the
// next edge: the head of the incoming word while loading, otherwise the stored head.
module piso_shreg #(
  parameter  int DATA_W    = 8,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_len,
  output logic              out_bit
);

  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] aligned;

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic head(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  // MSB-first words shorter than DATA_W are moved up so bit (len-1) is the head.
  always_comb begin
    aligned = load_data;
    if (!LSB_FIRST) aligned = load_data << (DATA_W - int'(load_len));
  end

  assign out_bit = load ? head(aligned) : head(sreg);

  // NOTE: pure datapath storage has no reset; the FSM never reads it before a load.
  always_ff @(posedge clk) begin
    if (load)          sreg <= step(aligned);
    else if (shift_en) sreg <= step(sreg);
  end

endmodule

// File: rtl/fsm_stim_tx.sv
// Serial bit transmitter: accepts a word on a valid/ready handshake and sends
// len bits, one per clock, followed by a one-cycle completion pulse.
module fsm_stim_tx
  import fsm_stim_pkg::*;
#(
  parameter  int   DATA_W    = 8,
  parameter  bit   LSB_FIRST = 1'b1,
  parameter  logic IDLE_BIT  = 1'b0,
  localparam int   CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_len,
  output logic              o_ready,
  output logic              o_serial,
  output logic              o_bit_valid,
  output logic              o_done,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, len_eff;
  logic             serial_nxt, bv_nxt, done_nxt;
  logic             load, shift_en, piso_bit;

  assign len_eff = CNT_W'(eff_len(int'(i_len), DATA_W));

  piso_shreg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (i_data),
    .load_len  (len_eff),
    .out_bit   (piso_bit)
  );

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_nxt  = ST_IDLE;
    cnt_nxt    = cnt;
    serial_nxt = IDLE_BIT;
    bv_nxt     = 1'b0;
    done_nxt   = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_valid) begin
          load       = 1'b1;
          state_nxt  = ST_SHIFT;
          cnt_nxt    = len_eff;
          serial_nxt = piso_bit;
          bv_nxt     = 1'b1;
        end
      end
      ST_SHIFT: begin
        // cnt counts bits still on the wire, including the one being presented.
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          shift_en   = 1'b1;
          state_nxt  = ST_SHIFT;
          cnt_nxt    = cnt - CNT_W'(1);
          serial_nxt = piso_bit;
          bv_nxt     = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_serial    <= IDLE_BIT;
      o_bit_valid <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_serial    <= serial_nxt;
      o_bit_valid <= bv_nxt;
      o_done      <= done_nxt;
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_busy  = !o_ready;
  assign o_state = state;

endmodule
